// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, geometry helpers and types.
// VGA_FRAME_CNT_EN (optional) adds a frame counter to vga_timing_gen.
package vga_timing_pkg;

    // 640x480@60
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // 800x600@60
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    typedef enum logic {
        ACTIVE_LOW  = 1'b0,
        ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    typedef struct packed {
        logic fs;
        logic ls;
        logic valid;
        logic vs;
        logic hs;
    } raw_t;

    function automatic int h_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages, W bits wide,
// cleared asynchronously to RST_VAL.
module vga_delay_line #(
    parameter int           W       = 5,
    parameter int           DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stg_q;
    logic [DEPTH-1:0][W-1:0] stg_d;

    always_comb begin
        stg_d = stg_q;
        if (en) begin
            stg_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stg_d[i] = stg_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_q <= {DEPTH{RST_VAL}};
        end else begin
            stg_q <= stg_d;
        end
    end

    assign dout = stg_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with strobe enable.
// VGA_FRAME_CNT_EN adds a 16-bit frame counter output frame_cnt.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11,
    parameter int PIPE_DLY = 1
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam sync_pol_e HS_P = sync_pol_e'(HS_POL);
    localparam sync_pol_e VS_P = sync_pol_e'(VS_POL);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_wrap;
    raw_t             raw;
    raw_t             dly;

    assign h_wrap = (h_q == H_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Decodes stay active-high; polarity is applied after the delay
    always_comb begin
        raw       = '0;
        raw.hs    = (h_q >= HS_BEG) && (h_q <= HS_END);
        raw.vs    = (v_q >= VS_BEG) && (v_q <= VS_END);
        raw.valid = (h_q < H_ACT) && (v_q < V_ACT);
        raw.ls    = (h_q == '0);
        raw.fs    = (h_q == '0) && (v_q == '0);
    end

    vga_delay_line #(
        .W       ($bits(raw_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ('0)
    ) u_dly (
        .clk   (pclk),
        .reset (reset),
        .en    (en),
        .din   (raw),
        .dout  (dly)
    );

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign hsync       = (HS_P == ACTIVE_HIGH) ? dly.hs : ~dly.hs;
    assign vsync       = (VS_P == ACTIVE_HIGH) ? dly.vs : ~dly.vs;
    assign valid       = dly.valid;
    assign line_start  = dly.ls;
    assign frame_start = dly.fs;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (en && h_wrap && (v_q == V_LAST)) begin
            fc_d = fc_q + 16'd1;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_cnt = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, random strobes,
// compared against an arithmetic model of strobe position.
module tb_vga_timing_gen;

    localparam int HA = 10;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 4;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int PD = 3;
    localparam int CW = 5;

    logic          pclk;
    logic          reset;
    logic          en;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          hsync;
    logic          vsync;
    logic          valid;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int k     = 0;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0),
        .CNT_W    (CW),
        .PIPE_DLY (PD)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .en          (en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hsync       (hsync),
        .vsync       (vsync),
        .valid       (valid),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h",
                   tag, k, obs, exp);
        end
    endtask

    // Strobe k: counters show position k; outputs show position k-PD.
    task automatic check_all(input string tag);
        int p, hh, vv;
        bit e_hs, e_vs, e_va, e_ls, e_fs;
        e_hs = 0; e_vs = 0; e_va = 0; e_ls = 0; e_fs = 0;
        p = k - PD;
        if (p >= 0) begin
            hh   = p % HT;
            vv   = (p / HT) % VT;
            e_hs = (hh >= HA + HF) && (hh < HA + HF + HS);
            e_vs = (vv >= VA + VF) && (vv < VA + VF + VS);
            e_va = (hh < HA) && (vv < VA);
            e_ls = (hh == 0);
            e_fs = (hh == 0) && (vv == 0);
        end
        chk({tag, ".h_cnt"}, 16'(h_cnt), 16'(k % HT));
        chk({tag, ".v_cnt"}, 16'(v_cnt), 16'((k / HT) % VT));
        chk({tag, ".hsync"}, 16'(hsync), 16'(e_hs));
        chk({tag, ".vsync"}, 16'(vsync), 16'(!e_vs));
        chk({tag, ".valid"}, 16'(valid), 16'(e_va));
        chk({tag, ".line_start"}, 16'(line_start), 16'(e_ls));
        chk({tag, ".frame_start"}, 16'(frame_start), 16'(e_fs));
`ifdef VGA_FRAME_CNT_EN
        chk({tag, ".frame_cnt"}, frame_cnt, 16'((k / FR) % 65536));
`endif
    endtask

    task automatic step(input bit e, input string tag);
        en = e;
        @(posedge pclk);
        #1;
        if (e) k++;
        check_all(tag);
    endtask

    initial begin
        int n_va, n_vs, n_ls;
        n_va = 0; n_vs = 0; n_ls = 0;
        reset = 1'b1;
        en    = 1'b1;
        #12;
        check_all("rst");

        @(posedge pclk);
        #1 reset = 1'b0;
        k = 0;
        check_all("rel");

        // Two frames of continuous strobes, tallying one full frame
        for (int i = 0; i < 2 * FR; i++) begin
            step(1'b1, "run");
            if (k >= PD && k < PD + FR) begin
                n_va += int'(valid);
                n_vs += int'(!vsync);
                n_ls += int'(line_start);
            end
        end
        chk("valid_per_frame", 16'(n_va), 16'(HA * VA));
        chk("vsync_per_frame", 16'(n_vs), 16'(VS * HT));
        chk("lines_per_frame", 16'(n_ls), 16'(VT));

        // Strict alternation, then random strobe pattern
        for (int i = 0; i < 200; i++) step(1'(i % 2 == 0), "alt");
        for (int i = 0; i < 700; i++) step(1'($urandom_range(3) != 0), "rnd");

        // Mid-frame asynchronous reset, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        k = 0;
        check_all("async_rst");
        @(posedge pclk);
        #1 reset = 1'b0;
        check_all("rst_rel");

        for (int i = 0; i < 3 * FR + 20; i++) begin
            step(1'($urandom_range(4) != 0), "post");
        end
        for (int i = 0; i < 2 * FR; i++) step(1'b1, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/SVGA raster timing generator. It drives hsync/vsync, the active-video flag and raster coordinates for the pixel pipeline and the frame-buffer address logic. Relative to the fixed 640x480 controller, it adds:
- a generic porch/sync geometry;
- selectable sync polarity;
- a pixel-enable strobe, so it can run from a faster clock;
- a configurable output delay to match pixel-fetch latency;
- line_start and frame_start pulses.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CNT_W, 11, counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)
PIPE_DLY, 1, pixel-strobe delay (>=1) from counter value to sync/valid/pulse outputs

Ports:
pclk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
en  in  1  pixel strobe; counters and delay line advance only when en=1
h_cnt  out  CNT_W  raw horizontal counter, 0..H_TOTAL-1 (undelayed; fetch address)
v_cnt  out  CNT_W  raw vertical counter, 0..V_TOTAL-1 (undelayed)
hsync  out  1  horizontal sync, polarity per HS_POL, delayed by PIPE_DLY
vsync  out  1  vertical sync, polarity per VS_POL, delayed by PIPE_DLY
valid  out  1  active video (h<H_ACTIVE and v<V_ACTIVE), delayed by PIPE_DLY
line_start  out  1  one-strobe pulse at h=0, delayed by PIPE_DLY
frame_start  out  1  one-strobe pulse at h=0 and v=0, delayed by PIPE_DLY

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent. Defaults give 800 and 525.
- Line layout is active, front porch, sync, back porch. Counters are 0-based.
- Reset is asynchronous and active-high. On reset:
  - h_cnt = v_cnt = 0;
  - hsync = ~HS_POL and vsync = ~VS_POL (inactive levels);
  - valid, line_start and frame_start = 0;
  - every delay-line stage is cleared to these inactive values.
- h counter: on each pclk edge with en=1, it increments. At H_TOTAL-1 it wraps to 0.
- v counter: it advances only when h wraps. At V_TOTAL-1 it wraps to 0, on the same edge as h.
- With en=0, all registers hold. Outputs stay stable, and pulses are stretched to whole strobe periods.
- Raw decode from the counters:
  - hs_raw is true for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751 with defaults;
  - vs_raw is true for v in 490..491 with defaults;
  - valid_raw = h<H_ACTIVE and v<V_ACTIVE;
  - ls_raw = (h==0);
  - fs_raw = (h==0 and v==0).
- Delay line: the raw decodes pass through a PIPE_DLY-stage register delay line clocked by en.
  - Output at strobe n reflects the counter value at strobe n-PIPE_DLY.
  - Polarity is applied after the delay: hsync = hs_d XNOR HS_POL.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). The raster restarts at h=0, v=0 on the first en edge after release.
- All arithmetic is unsigned in CNT_W bits. Parameters are elaborated constants; there are no run-time mode changes.

Optional Feature:
Macro name: VGA_FRAME_CNT_EN.
- Defined: adds output frame_cnt[15:0].
  - Reset value is 0.
  - Increments by 1 on each en edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Wraps 0xFFFF to 0.
  - Undelayed, i.e. aligned with h_cnt/v_cnt.
- Undefined: the port and its logic are absent.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480@60 timing constants;
  - an 800x600 constant set;
  - H_TOTAL/V_TOTAL helper functions;
  - a polarity enum (ACTIVE_LOW/ACTIVE_HIGH).
- One sub-module, vga_delay_line: a parametrised width/depth shift register with enable and async reset value. It is used here for the 5-bit raw-decode bundle.

Test Plan:
1. Reset pulse, then en=1 held, defaults -> after the first edge valid=1, h_cnt=1. hsync goes low after edge 657 and returns high after edge 753 (96 pclk low).
2. Free-run two frames, en=1 -> frame_start pulses exactly 420000 pclk apart. There are exactly 480 lines of valid per frame, each 640 pclk long, and vsync is low for exactly 1600 pclk.
3. en toggling 1,0,1,0 -> frame_start period is 840000 pclk. All outputs hold on en=0 cycles, and line_start is high for 2 pclk.
4. PIPE_DLY=3 -> the valid falling edge is seen 3 strobes after h_cnt reaches 640. hsync falls 3 strobes after h_cnt reaches 656.
5. Assert reset at h=300, v=200 for 1 cycle -> outputs are at reset values in the same cycle, without waiting for a clock edge. After release, h_cnt/v_cnt restart from 0, and frame_start appears PIPE_DLY strobes later.
6. HS_POL=1, VS_POL=1, VGA_FRAME_CNT_EN defined -> hsync is high for h=656..751 and vsync is high for v=490..491. frame_cnt reads 3 after 3 full frames.
